// File: rtl/rom_port_arbiter_pkg.sv
// Shared definitions for the boot/program ROM read-port arbiter:
// ROM geometry, FSM state encoding and the byte-address legality check.
package rom_port_arbiter_pkg;

  localparam int ROM_WORDS  = 512;
  localparam int ROM_ADDR_W = 9;
  localparam int ERR_W      = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // A byte address is unusable if it is not word aligned or lies outside the ROM region.
  function automatic logic addr_bad(input logic [31:0] a,
                                    input int unsigned aw,
                                    input logic [31:0] base_hi);
    return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != base_hi);
  endfunction

endpackage

// File: rtl/rom_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: lowest eligible index at or after rr_ptr,
// wrapping modulo NREQ.
module rr_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  mask,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] gidx,
  output logic             any
);

  logic [NREQ-1:0] elig;

  assign elig = req & ~mask;

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!any && elig[idx]) begin
        any        = 1'b1;
        gidx       = IDX_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one read port of the 512x32 boot ROM between NREQ requesters, round-robin,
// converting byte addresses to word addresses and returning data with a one-cycle ack.
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int          NREQ    = 2,
  parameter int          ADDR_W  = ROM_ADDR_W,
  parameter logic [31:0] BASE_HI = 32'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   addr,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      err,
  output logic [31:0]          rdata,
  output logic                 rom_en,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [31:0]          rom_dout,
  output logic                 busy
);

  localparam int IDX_W = $clog2(NREQ);

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] g;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] ptr_in;
  logic [NREQ-1:0]  mask;
  logic [NREQ-1:0]  win_grant;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic [31:0]      sel_addr;

  // While responding, the requester being acked still holds req, so hide it and
  // arbitrate from the pointer value it is about to hand on.
  assign ptr_next = (g == IDX_W'(NREQ - 1)) ? '0 : g + 1'b1;
  assign ptr_in   = (state == ST_RESP) ? ptr_next : rr_ptr;

  always_comb begin
    mask = '0;
    if (state == ST_RESP) mask[g] = 1'b1;
  end

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req    (req),
    .mask   (mask),
    .rr_ptr (ptr_in),
    .grant  (win_grant),
    .gidx   (win_idx),
    .any    (win_any)
  );

  assign sel_addr = addr[32*win_idx +: 32];
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      g        <= '0;
      ack      <= '0;
      err      <= '0;
      rdata    <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      ack    <= '0;
      err    <= '0;
      rom_en <= 1'b0;
      case (state)
        ST_ISSUE: begin
          // rom_dout was refreshed by the ROM at the mid-cycle negedge.
          state  <= ST_RESP;
          ack[g] <= 1'b1;
          rdata  <= rom_dout;
        end
        ST_IDLE, ST_RESP: begin
          if (state == ST_RESP) rr_ptr <= ptr_next;
          if (win_any) begin
            g <= win_idx;
            if (addr_bad(sel_addr, ADDR_W, BASE_HI)) begin
              state <= ST_RESP;
              ack   <= win_grant;
              err   <= win_grant;
              rdata <= '0;
            end else begin
              state    <= ST_ISSUE;
              rom_en   <= 1'b1;
              rom_addr <= sel_addr[ADDR_W+1:2];
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed and scoreboarded random test of rom_port_arbiter with four requesters
// and a behavioural ROM whose word k holds 32'hA5000000 | k.
module tb_rom_port_arbiter;

  localparam int NREQ = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] addr;
  logic [3:0]   ack;
  logic [3:0]   err;
  logic [31:0]  rdata;
  logic         rom_en;
  logic [8:0]   rom_addr;
  logic [31:0]  rom_dout = 32'd0;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] pend_addr [4];
  bit          pend_bad  [4];
  bit          pending   [4];
  int          others    [4];

  rom_port_arbiter #(.NREQ(NREQ), .ADDR_W(9), .BASE_HI(32'd0)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .addr     (addr),
    .ack      (ack),
    .err      (err),
    .rdata    (rdata),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // ROM registers its output on the falling edge when enabled.
  always @(negedge clk)
    if (rom_en) rom_dout <= 32'hA500_0000 | {23'd0, rom_addr};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input int idx, input logic [31:0] a);
    addr[32*idx +: 32] = a;
    req = r;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ack"},    32'(ack),    32'd0);
    checkOutput({tag, "_err"},    32'(err),    32'd0);
    checkOutput({tag, "_rom_en"}, 32'(rom_en), 32'd0);
    checkOutput({tag, "_busy"},   32'(busy),   32'd0);
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    addr = '0;
    tick;
    tick;
    checkIdle("reset");
    checkOutput("reset_rdata",    rdata,          32'd0);
    checkOutput("reset_rom_addr", 32'(rom_addr),  32'd0);
    rst = 1'b0;

    $display("[TB] single read of word 4");
    applyStimulus(4'b0001, 0, 32'h0000_0010);
    tick;
    checkOutput("t1_rom_en",   32'(rom_en),   32'd1);
    checkOutput("t1_rom_addr", 32'(rom_addr), 32'd4);
    checkOutput("t1_busy",     32'(busy),     32'd1);
    checkOutput("t1_ack_early",32'(ack),      32'd0);
    tick;
    checkOutput("t1_ack",   32'(ack), 32'b0001);
    checkOutput("t1_err",   32'(err), 32'd0);
    checkOutput("t1_rdata", rdata,    32'hA500_0004);
    req = 4'b0000;
    tick;
    checkIdle("t1_after");
    checkOutput("t1_rdata_hold", rdata, 32'hA500_0004);

    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkOutput("rst2_rdata", rdata, 32'd0);

    $display("[TB] two held requesters alternate");
    applyStimulus(4'b0000, 0, 32'h0000_0000);
    applyStimulus(4'b0011, 1, 32'h0000_0004);
    for (int k = 0; k < 4; k++) begin
      tick;
      checkOutput("t2_rom_en",   32'(rom_en),   32'd1);
      checkOutput("t2_rom_addr", 32'(rom_addr), 32'(k % 2));
      checkOutput("t2_ack_idle", 32'(ack),      32'd0);
      tick;
      checkOutput("t2_ack",   32'(ack), (k % 2 == 0) ? 32'b0001 : 32'b0010);
      checkOutput("t2_rdata", rdata,    32'hA500_0000 | 32'(k % 2));
    end
    req = 4'b0000;
    tick;
    checkIdle("t2_after");

    $display("[TB] misaligned address from requester 1");
    applyStimulus(4'b0010, 1, 32'h0000_0802);
    tick;
    checkOutput("t3_ack",    32'(ack),    32'b0010);
    checkOutput("t3_err",    32'(err),    32'b0010);
    checkOutput("t3_rdata",  rdata,       32'd0);
    checkOutput("t3_rom_en", 32'(rom_en), 32'd0);
    checkOutput("t3_busy",   32'(busy),   32'd1);
    req = 4'b0000;
    tick;
    checkIdle("t3_after");

    $display("[TB] out-of-range address from requester 0");
    applyStimulus(4'b0001, 0, 32'h0000_0800);
    tick;
    checkOutput("t4_ack",      32'(ack),      32'b0001);
    checkOutput("t4_err",      32'(err),      32'b0001);
    checkOutput("t4_rom_en",   32'(rom_en),   32'd0);
    checkOutput("t4_rom_addr", 32'(rom_addr), 32'd1);
    req = 4'b0000;
    tick;
    checkIdle("t4_after");

    $display("[TB] reset during ISSUE");
    applyStimulus(4'b0001, 0, 32'h0000_0020);
    tick;
    checkOutput("t5_rom_en",   32'(rom_en),   32'd1);
    checkOutput("t5_rom_addr", 32'(rom_addr), 32'd8);
    rst = 1'b1;
    tick;
    checkIdle("t5_reset");
    checkOutput("t5_rdata",    rdata,         32'd0);
    checkOutput("t5_rom_addr0",32'(rom_addr), 32'd0);
    rst = 1'b0;
    applyStimulus(4'b0101, 2, 32'h0000_0040);
    tick;
    checkOutput("t5_regrant_addr", 32'(rom_addr), 32'd8);
    checkOutput("t5_regrant_en",   32'(rom_en),   32'd1);
    tick;
    checkOutput("t5_ack0",   32'(ack), 32'b0001);
    checkOutput("t5_rdata0", rdata,    32'hA500_0008);
    req = 4'b0100;
    tick;
    checkOutput("t5_addr2", 32'(rom_addr), 32'd16);
    tick;
    checkOutput("t5_ack2",   32'(ack), 32'b0100);
    checkOutput("t5_rdata2", rdata,    32'hA500_0010);
    req = 4'b0000;
    tick;
    checkIdle("t5_after");

    $display("[TB] last ROM word");
    applyStimulus(4'b1000, 3, 32'h0000_07FC);
    tick;
    checkOutput("t6_rom_addr", 32'(rom_addr), 32'd511);
    checkOutput("t6_rom_en",   32'(rom_en),   32'd1);
    tick;
    checkOutput("t6_ack",   32'(ack), 32'b1000);
    checkOutput("t6_err",   32'(err), 32'd0);
    checkOutput("t6_rdata", rdata,    32'hA500_01FF);
    req = 4'b0000;
    tick;
    checkIdle("t6_after");

    $display("[TB] random traffic on four requesters");
    for (int i = 0; i < NREQ; i++) begin
      pending[i] = 1'b0;
      others[i]  = 0;
    end
    for (int cyc = 0; cyc < 460; cyc++) begin
      bit any_pend;
      checkOutput("rnd_ack_onehot", 32'(ack & (ack - 4'd1)), 32'd0);
      checkOutput("rnd_err_in_ack", 32'(err & ~ack),          32'd0);
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          checkOutput("rnd_ack_pending", 32'(pending[i]), 32'd1);
          checkOutput("rnd_err", 32'(err[i]), 32'(pend_bad[i]));
          checkOutput("rnd_rdata", rdata,
                      pend_bad[i] ? 32'd0 : (32'hA500_0000 | 32'(pend_addr[i][10:2])));
          checkOutput("rnd_fair", 32'(others[i] <= NREQ), 32'd1);
          pending[i] = 1'b0;
          req[i]     = 1'b0;
          for (int j = 0; j < NREQ; j++)
            if (j != i && pending[j]) others[j]++;
        end
      end
      any_pend = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (cyc < 400 && !pending[i] && !ack[i] && $urandom_range(0, 3) == 0) begin
          int unsigned kind;
          logic [8:0]  word;
          kind = $urandom_range(0, 7);
          word = 9'($urandom_range(0, 511));
          if (kind == 0)      pend_addr[i] = {21'd0, word, 2'($urandom_range(1, 3))};
          else if (kind == 1) pend_addr[i] = 32'h0000_0800 | {21'd0, word, 2'b00};
          else                pend_addr[i] = {21'd0, word, 2'b00};
          pend_bad[i] = (kind < 2);
          pending[i]  = 1'b1;
          others[i]   = 0;
          applyStimulus(req | (4'b0001 << i), i, pend_addr[i]);
        end
        if (pending[i]) any_pend = 1'b1;
      end
      if (cyc >= 400 && !any_pend) break;
      tick;
    end
    begin
      int left;
      left = 0;
      for (int i = 0; i < NREQ; i++) if (pending[i]) left++;
      checkOutput("rnd_drain", 32'(left), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
